// File: rtl/uart_tx_scheduler.sv
// Shares the UART TX frame engine between the ALU result path (two bytes, LSB first)
// and the register-file read path (one byte) with round-robin arbitration.
module uart_tx_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_valid,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_valid,
  input  logic                    tx_busy,
  input  logic                    clr_err,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    tx_d_valid,
  output logic                    sched_busy,
  output logic                    overrun,
  output logic                    timeout_err
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT);
  localparam logic GRANT_ALU = 1'b1;
  localparam logic GRANT_RD  = 1'b0;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, NEXT} state_e;

  state_e                  state_q, state_d;
  logic                    alu_pend_q, alu_pend_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [2*DATA_WIDTH-1:0] alu_buf_q, alu_buf_d;
  logic [DATA_WIDTH-1:0]   rd_buf_q, rd_buf_d;
  logic                    grant_q, grant_d;
  logic                    last_grant_q, last_grant_d;
  logic                    byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    overrun_q, overrun_d;
  logic                    timeout_q, timeout_d;

  logic                    rel_alu, rel_rd, timeout_set, overrun_set, pick;
  logic [CNT_W-1:0]        cnt_inc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      alu_pend_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
      alu_buf_q    <= '0;
      rd_buf_q     <= '0;
      grant_q      <= GRANT_RD;
      last_grant_q <= GRANT_ALU;
      byte_idx_q   <= 1'b0;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_pend_q   <= alu_pend_d;
      rd_pend_q    <= rd_pend_d;
      alu_buf_q    <= alu_buf_d;
      rd_buf_q     <= rd_buf_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      byte_idx_q   <= byte_idx_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  // The outgoing byte is loaded on every transition into SEND so it is already valid during the strobe.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    byte_idx_d   = byte_idx_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    rel_alu      = 1'b0;
    rel_rd       = 1'b0;
    timeout_set  = 1'b0;
    pick         = (alu_pend_q && rd_pend_q) ? ~last_grant_q : alu_pend_q;
    cnt_inc      = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (alu_pend_q || rd_pend_q) begin
          grant_d      = pick;
          last_grant_d = pick;
          byte_idx_d   = 1'b0;
          tx_data_d    = pick ? alu_buf_q[DATA_WIDTH-1:0] : rd_buf_q;
          state_d      = SEND;
        end
      end
      SEND: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc;
          if (cnt_q == CNT_MAX || cnt_inc == CNT_MAX) begin
            timeout_set = 1'b1;
            rel_alu     = (grant_q == GRANT_ALU);
            rel_rd      = (grant_q == GRANT_RD);
            state_d     = IDLE;
          end
        end
      end
      WAIT_LO: begin
        if (!tx_busy) state_d = NEXT;
      end
      NEXT: begin
        if (grant_q == GRANT_ALU && !byte_idx_q) begin
          byte_idx_d = 1'b1;
          tx_data_d  = alu_buf_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d    = SEND;
        end else begin
          rel_alu = (grant_q == GRANT_ALU);
          rel_rd  = (grant_q == GRANT_RD);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A strobe arriving in the release cycle of its own source is a fresh capture, not an overrun.
  always_comb begin
    alu_pend_d  = alu_pend_q & ~rel_alu;
    rd_pend_d   = rd_pend_q & ~rel_rd;
    alu_buf_d   = alu_buf_q;
    rd_buf_d    = rd_buf_q;
    overrun_set = 1'b0;
    if (alu_valid) begin
      if (!alu_pend_q || rel_alu) begin
        alu_pend_d = 1'b1;
        alu_buf_d  = alu_out;
      end else begin
        overrun_set = 1'b1;
      end
    end
    if (rd_valid) begin
      if (!rd_pend_q || rel_rd) begin
        rd_pend_d = 1'b1;
        rd_buf_d  = rd_data;
      end else begin
        overrun_set = 1'b1;
      end
    end
    overrun_d = overrun_set | (overrun_q & ~clr_err);
    timeout_d = timeout_set | (timeout_q & ~clr_err);
  end

  always_comb begin
    tx_p_data   = tx_data_q;
    tx_d_valid  = (state_q == SEND);
    sched_busy  = (state_q != IDLE) || alu_pend_q || rd_pend_q;
    overrun     = overrun_q;
    timeout_err = timeout_q;
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a TX engine model answers strobes, a monitor
// pops the expected byte queue on every strobe while the main process drives requests.
module tb_uart_tx_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] alu_out;
  logic        alu_valid;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        tx_busy;
  logic        clr_err;
  logic [7:0]  tx_p_data;
  logic        tx_d_valid;
  logic        sched_busy;
  logic        overrun;
  logic        timeout_err;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          strobeCount = 0;
  int          strobeCycs[$];
  logic [7:0]  expQ[$];
  bit          txRespond = 1'b1;

  uart_tx_scheduler #(.DATA_WIDTH(8), .BUSY_TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .alu_out(alu_out), .alu_valid(alu_valid),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .tx_busy(tx_busy), .clr_err(clr_err),
    .tx_p_data(tx_p_data), .tx_d_valid(tx_d_valid),
    .sched_busy(sched_busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic align();
    @(posedge CLK);
    #1;
  endtask

  task automatic goToCycle(input int c);
    while (cyc < c) align();
  endtask

  task automatic applyStimulus(input bit rdV, input logic [7:0] rdD, input bit aluV, input logic [15:0] aluD);
    rd_valid  = rdV;
    rd_data   = rdD;
    alu_valid = aluV;
    alu_out   = aluD;
    align();
    rd_valid  = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic pulseClear();
    clr_err = 1'b1;
    align();
    clr_err = 1'b0;
  endtask

  task automatic startScenario();
    strobeCount = 0;
    strobeCycs.delete();
  endtask

  task automatic waitIdle(input int budget, output int idleCyc);
    int n = 0;
    idleCyc = -1;
    @(negedge CLK);
    while (sched_busy !== 1'b0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (sched_busy !== 1'b0) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_wait: sched_busy=%0b still high after %0d cycles", sched_busy, budget);
    end else begin
      idleCyc = cyc;
    end
  endtask

  function automatic int strobeCycAt(input int i);
    if (i < strobeCycs.size()) return strobeCycs[i];
    return -1;
  endfunction

  // TX engine model: busy rises one cycle after a strobe and stays high for 10 cycles.
  initial begin : txModel
    int left;
    bit sawStrobe;
    left    = 0;
    tx_busy = 1'b0;
    forever begin
      @(negedge CLK);
      sawStrobe = (tx_d_valid === 1'b1);
      @(posedge CLK);
      #1;
      if (sawStrobe && txRespond) left = 10;
      else if (left > 0) left--;
      tx_busy = (left > 0);
    end
  end

  initial begin : monitor
    logic [7:0] exp;
    forever begin
      @(negedge CLK);
      if (tx_d_valid === 1'b1) begin
        strobeCount++;
        strobeCycs.push_back(cyc);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_strobe: actual data=%0h required=no frame", tx_p_data);
        end else begin
          exp = expQ.pop_front();
          checkOutput("frame_data", {24'h0, tx_p_data}, {24'h0, exp});
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int s0;
    int s1;
    int idleCyc;
    RST = 1'b1; alu_out = '0; alu_valid = 1'b0; rd_data = '0; rd_valid = 1'b0; clr_err = 1'b0;
    repeat (3) align();
    @(negedge CLK);
    checkOutput("reset_tx_p_data", {24'h0, tx_p_data}, 32'h0);
    checkOutput("reset_tx_d_valid", {31'h0, tx_d_valid}, 32'h0);
    checkOutput("reset_sched_busy", {31'h0, sched_busy}, 32'h0);
    checkOutput("reset_overrun", {31'h0, overrun}, 32'h0);
    checkOutput("reset_timeout_err", {31'h0, timeout_err}, 32'h0);
    align();
    RST = 1'b0;

    // RD only: strobe in cycle 2, NEXT at +14, idle at +15, byte held afterwards.
    align(); startScenario(); s0 = cyc;
    expQ.push_back(8'hA5);
    applyStimulus(1'b1, 8'hA5, 1'b0, 16'h0);
    goToCycle(s0 + 14); @(negedge CLK);
    checkOutput("rd_busy_in_next", {31'h0, sched_busy}, 32'h1);
    goToCycle(s0 + 15); @(negedge CLK);
    checkOutput("rd_idle_after_next", {31'h0, sched_busy}, 32'h0);
    checkOutput("rd_data_held", {24'h0, tx_p_data}, 32'hA5);
    checkOutput("rd_strobe_count", strobeCount, 1);
    checkOutput("rd_strobe_cycle", strobeCycAt(0), s0 + 2);

    // ALU two-byte: busy falls at +13, second strobe at +15, idle at +28.
    align(); startScenario(); s0 = cyc;
    expQ.push_back(8'h34); expQ.push_back(8'h12);
    applyStimulus(1'b0, 8'h0, 1'b1, 16'h1234);
    waitIdle(100, idleCyc);
    checkOutput("alu_strobe_count", strobeCount, 2);
    checkOutput("alu_first_strobe", strobeCycAt(0), s0 + 2);
    checkOutput("alu_second_strobe", strobeCycAt(1), s0 + 15);
    checkOutput("alu_idle_cycle", idleCyc, s0 + 28);

    // Tie after reset: RD wins, then ALU.
    align(); startScenario();
    expQ.push_back(8'h55); expQ.push_back(8'hEF); expQ.push_back(8'hBE);
    applyStimulus(1'b1, 8'h55, 1'b1, 16'hBEEF);
    waitIdle(200, idleCyc);
    checkOutput("tie1_strobe_count", strobeCount, 3);
    // An RD-only frame leaves last grant on RD, so the next tie goes to the ALU.
    align();
    expQ.push_back(8'h66);
    applyStimulus(1'b1, 8'h66, 1'b0, 16'h0);
    waitIdle(100, idleCyc);
    align(); startScenario();
    expQ.push_back(8'hEF); expQ.push_back(8'hBE); expQ.push_back(8'h55);
    applyStimulus(1'b1, 8'h55, 1'b1, 16'hBEEF);
    waitIdle(200, idleCyc);
    checkOutput("tie2_strobe_count", strobeCount, 3);

    // Overrun: second RD during WAIT_LO is dropped.
    align(); startScenario(); s0 = cyc;
    expQ.push_back(8'h11);
    applyStimulus(1'b1, 8'h11, 1'b0, 16'h0);
    goToCycle(s0 + 6); @(negedge CLK);
    checkOutput("ovr_before", {31'h0, overrun}, 32'h0);
    align();
    applyStimulus(1'b1, 8'h22, 1'b0, 16'h0);
    @(negedge CLK);
    checkOutput("ovr_set", {31'h0, overrun}, 32'h1);
    waitIdle(100, idleCyc);
    checkOutput("ovr_strobe_count", strobeCount, 1);
    checkOutput("ovr_sticky", {31'h0, overrun}, 32'h1);
    align(); pulseClear(); @(negedge CLK);
    checkOutput("ovr_cleared", {31'h0, overrun}, 32'h0);

    // Overrun coinciding with clr_err: the set wins.
    align(); startScenario(); s0 = cyc;
    expQ.push_back(8'h33);
    applyStimulus(1'b1, 8'h33, 1'b0, 16'h0);
    goToCycle(s0 + 6);
    clr_err = 1'b1;
    applyStimulus(1'b1, 8'h44, 1'b0, 16'h0);
    clr_err = 1'b0;
    @(negedge CLK);
    checkOutput("ovr_set_beats_clr", {31'h0, overrun}, 32'h1);
    waitIdle(100, idleCyc);
    align(); pulseClear();

    // Release and capture of RD in its NEXT cycle: captured, no overrun.
    align(); startScenario(); s0 = cyc;
    expQ.push_back(8'h5A); expQ.push_back(8'hC3);
    applyStimulus(1'b1, 8'h5A, 1'b0, 16'h0);
    goToCycle(s0 + 14);
    applyStimulus(1'b1, 8'hC3, 1'b0, 16'h0);
    @(negedge CLK);
    checkOutput("recapture_no_overrun", {31'h0, overrun}, 32'h0);
    waitIdle(100, idleCyc);
    checkOutput("recapture_strobe_count", strobeCount, 2);
    checkOutput("recapture_second_strobe", strobeCycAt(1), s0 + 16);

    // Timeout: WAIT_HI entered at +3, error visible 16 cycles later.
    txRespond = 1'b0;
    align(); startScenario(); s0 = cyc;
    expQ.push_back(8'h99);
    applyStimulus(1'b1, 8'h99, 1'b0, 16'h0);
    goToCycle(s0 + 18); @(negedge CLK);
    checkOutput("to_not_yet", {31'h0, timeout_err}, 32'h0);
    checkOutput("to_busy_before", {31'h0, sched_busy}, 32'h1);
    goToCycle(s0 + 19); @(negedge CLK);
    checkOutput("to_set", {31'h0, timeout_err}, 32'h1);
    checkOutput("to_pending_cleared", {31'h0, sched_busy}, 32'h0);
    goToCycle(s0 + 40); @(negedge CLK);
    checkOutput("to_no_retry", strobeCount, 1);
    align(); pulseClear(); @(negedge CLK);
    checkOutput("to_cleared", {31'h0, timeout_err}, 32'h0);
    align(); startScenario(); s0 = cyc;
    expQ.push_back(8'hCD);
    applyStimulus(1'b0, 8'h0, 1'b1, 16'hABCD);
    goToCycle(s0 + 19); @(negedge CLK);
    checkOutput("to_alu_set", {31'h0, timeout_err}, 32'h1);
    goToCycle(s0 + 50); @(negedge CLK);
    checkOutput("to_alu_no_byte1", strobeCount, 1);
    txRespond = 1'b1;
    align(); pulseClear();

    // Reset during WAIT_LO of an ALU frame, with overrun set beforehand.
    align(); startScenario(); s0 = cyc;
    expQ.push_back(8'h78);
    applyStimulus(1'b0, 8'h0, 1'b1, 16'h5678);
    goToCycle(s0 + 3);
    applyStimulus(1'b0, 8'h0, 1'b1, 16'h1111);
    @(negedge CLK);
    checkOutput("rst_pre_overrun", {31'h0, overrun}, 32'h1);
    goToCycle(s0 + 6);
    RST = 1'b1;
    align(); @(negedge CLK);
    checkOutput("rst_mid_tx_p_data", {24'h0, tx_p_data}, 32'h0);
    checkOutput("rst_mid_tx_d_valid", {31'h0, tx_d_valid}, 32'h0);
    checkOutput("rst_mid_sched_busy", {31'h0, sched_busy}, 32'h0);
    checkOutput("rst_mid_overrun", {31'h0, overrun}, 32'h0);
    checkOutput("rst_mid_timeout_err", {31'h0, timeout_err}, 32'h0);
    align();
    RST = 1'b0;
    goToCycle(s0 + 16);
    startScenario(); s1 = cyc;
    expQ.push_back(8'hBC); expQ.push_back(8'h9A);
    applyStimulus(1'b0, 8'h0, 1'b1, 16'h9ABC);
    waitIdle(100, idleCyc);
    checkOutput("post_rst_strobe_count", strobeCount, 2);
    checkOutput("post_rst_first_strobe", strobeCycAt(0), s1 + 2);

    repeat (5) align();
    checkOutput("queue_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
